serial_shifter: RTL and testbench
=================================

SERIAL_SHIFTER -- requirements
Module: serial_shifter

Interface
REQ-001 Parameter WIDTH, default 8: shift word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift toward MSB (ser_out from bit WIDTH-1); 0 = shift toward LSB (ser_out from bit 0).
REQ-003 Parameter IDLE_LEVEL, default 1: ser_out level when not shifting.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 clr  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  load din and begin a WIDTH-bit transfer.
REQ-007 din  in  WIDTH  parallel transmit word.
REQ-008 shift_en  in  1  bit strobe; one bit is shifted per clock where shift_en=1 during SHIFT.
REQ-009 ser_in  in  1  serial receive bit, sampled on a qualified shift.
REQ-010 rd_ack  in  1  consumer has read qout; clears rx_full.
REQ-011 ser_out  out  1  serial transmit bit.
REQ-012 qout  out  WIDTH  last completed received word (holding register).
REQ-013 busy  out  1  high in SHIFT state.
REQ-014 done  out  1  one-cycle pulse on transfer completion.
REQ-015 rx_full  out  1  qout holds an unacknowledged word.
REQ-016 overrun  out  1  sticky: a word completed while rx_full=1 and rd_ack=0.

Function
REQ-017 The block SHALL implement states IDLE, SHIFT and DONE, and SHALL hold each state until a listed transition occurs.
REQ-018 IDLE: start=1 loads din into the shift register, clears the bit counter, and moves to SHIFT; shift_en is ignored in that cycle.
REQ-019 SHIFT: on each shift_en=1 cycle, the register SHALL shift one position in the MSB_FIRST direction, ser_in SHALL enter the vacated end, and the counter SHALL increment.
REQ-020 SHIFT: shift_en=0 SHALL leave the register and counter unchanged; gaps of any length are legal.
REQ-021 The shift that brings the counter to WIDTH SHALL move to DONE; the counter width SHALL be $clog2(WIDTH+1) bits.
REQ-022 DONE lasts exactly one cycle: done=1, qout takes the completed register value, rx_full sets, and the state returns to IDLE.
REQ-023 start in DONE SHALL be accepted as in IDLE (load din, go to SHIFT) for back-to-back transfers; done still pulses.
REQ-024 start while busy=1 SHALL be ignored, with no effect on the register, counter or din capture.
REQ-025 ser_out SHALL be the outgoing register bit (WIDTH-1 or 0 per MSB_FIRST) in SHIFT and DONE, and IDLE_LEVEL in IDLE.
REQ-026 qout SHALL change only in DONE; it holds otherwise.
REQ-027 rd_ack=1 SHALL clear rx_full and overrun in the same edge, unless a DONE occurs in that cycle; then rx_full stays 1 and overrun is unchanged.
REQ-028 DONE with rx_full=1 and rd_ack=0 SHALL set overrun and overwrite qout with the new word.
REQ-029 done and busy SHALL never both be 1, except when a start is accepted in DONE (busy rises next cycle).

Reset
REQ-030 clr=0 at a rising clk SHALL force state IDLE, register 0, counter 0, qout 0, busy 0, done 0, rx_full 0, overrun 0, and ser_out IDLE_LEVEL.
REQ-031 clr=0 mid-transfer SHALL abort the transfer with no done pulse and no qout update; clr SHALL take priority over all inputs.
REQ-032 Reset SHALL have no asynchronous path; a clr pulse that covers no rising edge has no effect.

Verification
REQ-033 WIDTH=8, MSB_FIRST=1, ser_in looped from ser_out, din=8'hA5, 8 strobes -> ser_out sequence 1,0,1,0,0,1,0,1; qout=8'hA5; done pulses once; rx_full=1.
REQ-034 MSB_FIRST=0, din=8'h00, ser_in driven 1,1,0,0,1,0,1,0 over 8 gapped strobes -> qout=8'h53; busy high throughout the gaps.
REQ-035 Two transfers without rd_ack -> second done sets overrun=1 and qout holds the second word; next rd_ack -> rx_full=0, overrun=0.
REQ-036 clr=0 after 4 of 8 strobes -> next cycle busy=0, ser_out=1, no done pulse, qout keeps its prior value of 0.
REQ-037 start asserted during SHIFT with a different din -> ignored, original word completes; start in the DONE cycle -> new transfer starts with no idle cycle.

Source files
------------

// File: rtl/serial_shifter_if.sv
// Handshake and data bundle for serial_shifter: control/parallel data in,
// serial bit out, received word and status flags back.
interface serial_shifter_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             shift_en;
  logic             ser_in;
  logic             rd_ack;
  logic             ser_out;
  logic [WIDTH-1:0] qout;
  logic             busy;
  logic             done;
  logic             rx_full;
  logic             overrun;

  modport master (
    output start, din, shift_en, ser_in, rd_ack,
    input  ser_out, qout, busy, done, rx_full, overrun
  );

  modport slave (
    input  start, din, shift_en, ser_in, rd_ack,
    output ser_out, qout, busy, done, rx_full, overrun
  );
endinterface

// File: rtl/serial_shifter.sv
// Full-duplex serial shifter: loads a word, shifts it out one bit per strobe
// while shifting ser_in in, and parks each completed word in a holding register.
//
// state | meaning
// IDLE  | waiting for start; ser_out at IDLE_LEVEL
// SHIFT | transfer in progress, one bit per shift_en
// DONE  | single-cycle completion; word latched into qout
module serial_shifter #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input logic             clk,
  input logic             clr,
  serial_shifter_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] qout_r;
  logic             rx_full_r;
  logic             overrun_r;
  logic [WIDTH-1:0] sreg_shifted;
  logic             out_bit;

  always_comb begin
    if (MSB_FIRST) begin
      sreg_shifted = {sreg[WIDTH-2:0], bus.ser_in};
      out_bit      = sreg[WIDTH-1];
    end else begin
      sreg_shifted = {bus.ser_in, sreg[WIDTH-1:1]};
      out_bit      = sreg[0];
    end
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          sreg_nxt  = bus.din;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // start is deliberately not looked at here
        if (bus.shift_en) begin
          sreg_nxt = sreg_shifted;
          cnt_nxt  = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          sreg_nxt  = bus.din;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A completion outranks rd_ack: the fresh word must not be dropped as read.
  always_ff @(posedge clk) begin
    if (!clr) begin
      qout_r    <= '0;
      rx_full_r <= 1'b0;
      overrun_r <= 1'b0;
    end else if (state == DONE) begin
      qout_r    <= sreg;
      rx_full_r <= 1'b1;
      if (rx_full_r && !bus.rd_ack) overrun_r <= 1'b1;
    end else if (bus.rd_ack) begin
      rx_full_r <= 1'b0;
      overrun_r <= 1'b0;
    end
  end

  assign bus.busy    = (state == SHIFT);
  assign bus.done    = (state == DONE);
  assign bus.ser_out = (state == IDLE) ? IDLE_LEVEL : out_bit;
  assign bus.qout    = qout_r;
  assign bus.rx_full = rx_full_r;
  assign bus.overrun = overrun_r;
endmodule

// File: tb/tb_serial_shifter.sv
// Directed bench for serial_shifter: an MSB-first instance with loopback and an
// LSB-first instance fed explicit serial bits.
module tb_serial_shifter;
  logic clk;
  logic clr;
  int   n_tests;
  int   n_fail;
  int   done_cnt_m;

  serial_shifter_if #(.WIDTH(8)) bus_m ();
  serial_shifter_if #(.WIDTH(8)) bus_l ();

  serial_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
    .clk(clk), .clr(clr), .bus(bus_m)
  );
  serial_shifter #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk(clk), .clr(clr), .bus(bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus_m.done) done_cnt_m++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one loopback strobe on the MSB-first instance
  task automatic strobe_m();
    bus_m.ser_in   = bus_m.ser_out;
    bus_m.shift_en = 1'b1;
    step();
    bus_m.shift_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] seq_a5;
    int         seq_l [8];

    seq_a5 = 8'hA5;
    seq_l  = '{1, 1, 0, 0, 1, 0, 1, 0};
    n_tests = 0; n_fail = 0; done_cnt_m = 0;
    clr = 1'b0;
    bus_m.start = 0; bus_m.din = '0; bus_m.shift_en = 0; bus_m.ser_in = 0; bus_m.rd_ack = 0;
    bus_l.start = 0; bus_l.din = '0; bus_l.shift_en = 0; bus_l.ser_in = 0; bus_l.rd_ack = 0;
    step(); step();

    check("rst_busy",    bus_m.busy, 0);
    check("rst_done",    bus_m.done, 0);
    check("rst_rx_full", bus_m.rx_full, 0);
    check("rst_overrun", bus_m.overrun, 0);
    check("rst_qout",    bus_m.qout, 0);
    check("rst_ser_out", bus_m.ser_out, 1);
    check("rst_ser_out_l", bus_l.ser_out, 1);

    // abort mid-transfer; a clr glitch between edges must be ignored
    clr = 1'b1;
    step();
    bus_m.din = 8'hA5; bus_m.start = 1'b1;
    step();
    bus_m.start = 1'b0;
    check("abort_busy0", bus_m.busy, 1);
    check("abort_sout0", bus_m.ser_out, 1);
    #2 clr = 1'b0;
    #2 clr = 1'b1;
    bus_m.ser_in = 1'b0;
    bus_m.shift_en = 1'b1;
    repeat (4) step();
    check("glitch_busy", bus_m.busy, 1);
    check("abort_sout4", bus_m.ser_out, 0);
    clr = 1'b0;
    step();
    bus_m.shift_en = 1'b0;
    check("abort_busy",  bus_m.busy, 0);
    check("abort_sout",  bus_m.ser_out, 1);
    check("abort_done",  bus_m.done, 0);
    check("abort_qout",  bus_m.qout, 0);
    clr = 1'b1;
    step();
    check("abort_ndone", done_cnt_m, 0);

    // MSB-first loopback of A5; shift_en in the start cycle is ignored
    bus_m.din = 8'hA5; bus_m.start = 1'b1; bus_m.shift_en = 1'b1;
    step();
    bus_m.start = 1'b0; bus_m.shift_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("a5_bit%0d", i), bus_m.ser_out, seq_a5[7-i]);
      strobe_m();
    end
    check("a5_done",      bus_m.done, 1);
    check("a5_busy_done", bus_m.busy, 0);
    step();
    check("a5_qout",    bus_m.qout, 8'hA5);
    check("a5_rx_full", bus_m.rx_full, 1);
    check("a5_done_lo", bus_m.done, 0);
    check("a5_ndone",   done_cnt_m, 1);

    // second word without rd_ack -> overrun
    bus_m.din = 8'h3C; bus_m.start = 1'b1;
    step();
    bus_m.start = 1'b0;
    repeat (8) strobe_m();
    step();
    check("ovr_qout",    bus_m.qout, 8'h3C);
    check("ovr_flag",    bus_m.overrun, 1);
    check("ovr_rx_full", bus_m.rx_full, 1);
    bus_m.rd_ack = 1'b1;
    step();
    bus_m.rd_ack = 1'b0;
    check("ack_rx_full", bus_m.rx_full, 0);
    check("ack_overrun", bus_m.overrun, 0);

    // start during SHIFT ignored; start in DONE chains with no idle cycle
    bus_m.din = 8'h96; bus_m.start = 1'b1;
    step();
    bus_m.start = 1'b0;
    repeat (3) strobe_m();
    bus_m.din = 8'h11; bus_m.start = 1'b1;
    step();
    bus_m.start = 1'b0;
    check("ign_busy", bus_m.busy, 1);
    repeat (5) strobe_m();
    check("chain_done", bus_m.done, 1);
    bus_m.din = 8'h0F; bus_m.start = 1'b1; bus_m.rd_ack = 1'b1;
    step();
    bus_m.start = 1'b0; bus_m.rd_ack = 1'b0;
    check("chain_busy",    bus_m.busy, 1);
    check("chain_done_lo", bus_m.done, 0);
    check("chain_qout",    bus_m.qout, 8'h96);
    check("chain_rx_full", bus_m.rx_full, 1);
    check("chain_sout",    bus_m.ser_out, 0);
    repeat (8) strobe_m();
    step();
    check("chain2_qout", bus_m.qout, 8'h0F);
    check("chain2_ovr",  bus_m.overrun, 1);
    check("total_ndone", done_cnt_m, 4);

    // LSB-first, explicit serial bits with gaps
    bus_l.din = 8'h00; bus_l.start = 1'b1;
    step();
    bus_l.start = 1'b0;
    check("lsb_sout", bus_l.ser_out, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (2) step();
      check($sformatf("lsb_gap_busy%0d", i), bus_l.busy, 1);
      bus_l.ser_in = seq_l[i][0];
      bus_l.shift_en = 1'b1;
      step();
      bus_l.shift_en = 1'b0;
    end
    check("lsb_done", bus_l.done, 1);
    step();
    check("lsb_qout",    bus_l.qout, 8'h53);
    check("lsb_rx_full", bus_l.rx_full, 1);
    check("lsb_idle",    bus_l.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
